re_control: RTL and testbench
=============================

Name: re_control

Overview:
- Exposure/readout sequencer for the two-row pixel array in the camera front end.
- `init` starts one capture: expose the pixels for a programmable number of clock cycles, then read out row 1 and row 2 with an ADC strobe each. `erase` is held in idle.
- Exposure length is held in an internal register, stepped by `increase`/`decrease` between captures.
- Clocked at 1 kHz in the system, so 1 cycle = 1 ms of exposure.

Parameters:
- EXP_W, 5, width of the exposure register and exposure counter.
- EXP_MIN, 2, minimum exposure in cycles.
- EXP_MAX, 30, maximum exposure in cycles.
- EXP_DEFAULT, 5, exposure value after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- init  input  1  start-capture request, level-sampled in IDLE.
- increase  input  1  exposure +1 per cycle asserted (IDLE only).
- decrease  input  1  exposure -1 per cycle asserted (IDLE only).
- NRE_1  output  1  row-1 read enable, active low.
- NRE_2  output  1  row-2 read enable, active low.
- ADC  output  1  ADC conversion strobe, active high.
- expose  output  1  pixel exposure, active high.
- erase  output  1  pixel erase, active high.

Behaviour:
- Clock and reset: one clock domain, `clk`. `reset` is synchronous and active-high.
- Reset:
  - State goes to IDLE; the exposure register loads EXP_DEFAULT.
  - Outputs: erase=1, expose=0, NRE_1=1, NRE_2=1, ADC=0.
  - Reset wins over all other inputs and aborts any capture at once.
- Outputs are Moore: decoded only from the state register, no combinational path from inputs.
- States and output values:
  - IDLE: erase=1, all other outputs inactive.
  - EXPOSE: expose=1, erase=0.
  - R1A: NRE_1=0.
  - R1B: NRE_1=0, ADC=1.
  - R1C: NRE_1=0.
  - GAP: all outputs inactive, erase=0.
  - R2A: NRE_2=0.
  - R2B: NRE_2=0, ADC=1.
  - R2C: NRE_2=0.
- Transitions:
  - IDLE → EXPOSE when init=1 at a clock edge; the exposure counter loads the exposure register.
  - EXPOSE lasts exactly exposure-register cycles, then → R1A.
  - R1A → R1B → R1C → GAP → R2A → R2B → R2C → IDLE, one cycle each.
- Timing:
  - Total capture = exposure + 7 cycles.
  - expose rises in the cycle after the edge that sampled init.
- init is ignored outside IDLE. If init is still high when the FSM returns to IDLE, a new capture starts on the next edge (level-triggered).
- Exposure register:
  - Updated only while in IDLE and when init=0 on that edge. On an edge with init=1, the start wins and the register is unchanged.
  - increase alone: +1, saturating at EXP_MAX.
  - decrease alone: -1, saturating at EXP_MIN.
  - Both high: no change.
  - Changes during a capture are ignored; the value used by a capture is fixed when EXPOSE is entered.
- NRE_1 and NRE_2 are never low in the same cycle. ADC is high only while exactly one NRE is low.

Optional Feature:
- Macro RE_BUSY_OUT_EN.
- Defined: adds output port `busy` (1 bit), placed after `erase`. busy=1 in every state except IDLE; 0 in reset.
- Undefined: the port does not exist; all other behaviour is identical.

Decomposition:
- Package re_control_pkg holds:
  - the state enum (IDLE, EXPOSE, R1A, R1B, R1C, GAP, R2A, R2B, R2C);
  - constants EXP_W, EXP_MIN, EXP_MAX, EXP_DEFAULT.
- One sub-module, re_exposure_reg: the saturating up/down exposure register plus the exposure down-counter. It takes load/enable from the FSM and returns a done flag.
- The FSM and output decode stay in re_control.

Test Plan:
- Default capture: reset, then init high for 2 cycles → expose high exactly 5 cycles; NRE_1 low 3 cycles with ADC in the middle one; 1 idle-output cycle; NRE_2 low 3 cycles with ADC in the middle one; then erase=1.
- Adjust: in IDLE pulse increase for 1 cycle, twice (cycles apart) → exposure 7; next init gives expose high exactly 7 cycles.
- Saturation:
  - increase held 40 cycles → next capture expose = 30 cycles;
  - decrease held 40 cycles → expose = 2 cycles;
  - increase and decrease high together → value unchanged.
- Ignore while busy:
  - increase and decrease pulsed during EXPOSE and readout → next capture uses the old exposure;
  - init pulse during EXPOSE → no restart, sequence length unchanged.
- Reset mid-EXPOSE after an increase to 6 → next cycle all outputs at reset values; next capture exposes 5 cycles.
- init held high continuously → back-to-back captures separated by exactly one IDLE cycle (erase=1 for 1 cycle).

Source files
------------

// File: rtl/re_control_pkg.sv
// Shared types and constants for the re_control exposure/readout sequencer.
// Optional feature macro: RE_BUSY_OUT_EN (adds a registered busy output).
package re_control_pkg;

  localparam int EXP_W       = 5;
  localparam int EXP_MIN     = 2;
  localparam int EXP_MAX     = 30;
  localparam int EXP_DEFAULT = 5;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    EXPOSE = 4'd1,
    R1A    = 4'd2,
    R1B    = 4'd3,
    R1C    = 4'd4,
    GAP    = 4'd5,
    R2A    = 4'd6,
    R2B    = 4'd7,
    R2C    = 4'd8
  } state_e;

  typedef struct packed {
    logic nre_1;
    logic nre_2;
    logic adc;
    logic expose;
    logic erase;
  } out_t;

  // Moore output decode: one fixed output pattern per sequencer state.
  function automatic out_t decode_outputs(input state_e s);
    out_t o;
    o = '{nre_1: 1'b1, nre_2: 1'b1, adc: 1'b0, expose: 1'b0, erase: 1'b0};
    case (s)
      IDLE:    o.erase  = 1'b1;
      EXPOSE:  o.expose = 1'b1;
      R1A:     o.nre_1  = 1'b0;
      R1B:     begin o.nre_1 = 1'b0; o.adc = 1'b1; end
      R1C:     o.nre_1  = 1'b0;
      GAP:     o.erase  = 1'b0;
      R2A:     o.nre_2  = 1'b0;
      R2B:     begin o.nre_2 = 1'b0; o.adc = 1'b1; end
      R2C:     o.nre_2  = 1'b0;
      default: o.erase  = 1'b1;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/re_exposure_reg.sv
// Saturating up/down exposure register plus the exposure down-counter.
// The counter is loaded from the register when a capture starts, so any
// later register adjustment cannot disturb a capture already in progress.
module re_exposure_reg
  import re_control_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic adj_en_i,
  input  logic inc_i,
  input  logic dec_i,
  input  logic load_i,
  input  logic cnt_en_i,
  output logic done_o
);

  logic [EXP_W-1:0] exp_q;
  logic [EXP_W-1:0] exp_d;
  logic [EXP_W-1:0] cnt_q;
  logic [EXP_W-1:0] cnt_d;

  // Exposure register next value: single-step adjust with saturation; both
  // buttons together cancel out.
  always_comb begin
    exp_d = exp_q;
    if (adj_en_i && inc_i && !dec_i) begin
      if (exp_q < EXP_W'(EXP_MAX)) begin
        exp_d = exp_q + EXP_W'(1);
      end else begin
        exp_d = EXP_W'(EXP_MAX);
      end
    end else if (adj_en_i && dec_i && !inc_i) begin
      if (exp_q > EXP_W'(EXP_MIN)) begin
        exp_d = exp_q - EXP_W'(1);
      end else begin
        exp_d = EXP_W'(EXP_MIN);
      end
    end else begin
      exp_d = exp_q;
    end
  end

  // Down-counter next value: load at capture start, count during EXPOSE.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = exp_q;
    end else if (cnt_en_i && (cnt_q != EXP_W'(0))) begin
      cnt_d = cnt_q - EXP_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Register and counter state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      exp_q <= EXP_W'(EXP_DEFAULT);
      cnt_q <= EXP_W'(0);
    end else begin
      exp_q <= exp_d;
      cnt_q <= cnt_d;
    end
  end

  // The counter starts at the exposure value in the first EXPOSE cycle, so
  // the last EXPOSE cycle is the one where it reads 1.
  assign done_o = (cnt_q == EXP_W'(1));

endmodule

// File: rtl/re_control.sv
// Exposure/readout sequencer for the two-row pixel array.
// Optional feature macro: RE_BUSY_OUT_EN adds output busy (high outside IDLE).
// Outputs are registered from the decoded next state, so each output flop
// holds exactly the pattern of the current state with no input-to-output path.
module re_control
  import re_control_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic init,
  input  logic increase,
  input  logic decrease,
  output logic NRE_1,
  output logic NRE_2,
  output logic ADC,
  output logic expose,
  output logic erase
`ifdef RE_BUSY_OUT_EN
  ,
  output logic busy
`endif
);

  state_e state_q;
  state_e state_d;
  out_t   out_q;
  logic   exp_done_s;
  logic   in_idle_s;

  assign in_idle_s = (state_q == IDLE);

  re_exposure_reg u_exposure_reg (
    .clk_i    (clk),
    .reset_i  (reset),
    .adj_en_i (in_idle_s && !init),
    .inc_i    (increase),
    .dec_i    (decrease),
    .load_i   (in_idle_s && init),
    .cnt_en_i (state_q == EXPOSE),
    .done_o   (exp_done_s)
  );

  // Next-state logic: wait for init, expose for the programmed time, then
  // walk the fixed readout sequence one cycle per state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (init) begin
          state_d = EXPOSE;
        end else begin
          state_d = IDLE;
        end
      end
      EXPOSE: begin
        if (exp_done_s) begin
          state_d = R1A;
        end else begin
          state_d = EXPOSE;
        end
      end
      R1A:     state_d = R1B;
      R1B:     state_d = R1C;
      R1C:     state_d = GAP;
      GAP:     state_d = R2A;
      R2A:     state_d = R2B;
      R2B:     state_d = R2C;
      R2C:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and registered output decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      out_q   <= decode_outputs(IDLE);
    end else begin
      state_q <= state_d;
      out_q   <= decode_outputs(state_d);
    end
  end

  assign NRE_1  = out_q.nre_1;
  assign NRE_2  = out_q.nre_2;
  assign ADC    = out_q.adc;
  assign expose = out_q.expose;
  assign erase  = out_q.erase;

`ifdef RE_BUSY_OUT_EN
  logic busy_q;

  // Busy flag tracks every non-IDLE state.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
    end
  end

  assign busy = busy_q;
`endif

endmodule

// File: tb/tb_re_control.sv
// Self-checking bench for re_control with a cycle-time reference model.
module tb_re_control;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic init = 1'b0;
  logic increase = 1'b0;
  logic decrease = 1'b0;
  logic NRE_1, NRE_2, ADC, expose, erase;
`ifdef RE_BUSY_OUT_EN
  logic busy;
`endif

  int checks = 0;
  int passed = 0;

  re_control dut (
    .clk      (clk),
    .reset    (reset),
    .init     (init),
    .increase (increase),
    .decrease (decrease),
    .NRE_1    (NRE_1),
    .NRE_2    (NRE_2),
    .ADC      (ADC),
    .expose   (expose),
    .erase    (erase)
`ifdef RE_BUSY_OUT_EN
    ,
    .busy     (busy)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a capture is a timeline t = 0 .. E+6 after the start edge.
  bit m_busy = 1'b0;
  int m_t    = 0;
  int m_E    = 5;
  int m_exp  = 5;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_t    <= 0;
      m_exp  <= 5;
    end else if (!m_busy) begin
      if (init) begin
        m_busy <= 1'b1;
        m_t    <= 0;
        m_E    <= m_exp;
      end else if (increase && !decrease) begin
        m_exp <= (m_exp < 30) ? m_exp + 1 : 30;
      end else if (decrease && !increase) begin
        m_exp <= (m_exp > 2) ? m_exp - 1 : 2;
      end
    end else if (m_t == m_E + 6) begin
      m_busy <= 1'b0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  // Expected {NRE_1, NRE_2, ADC, expose, erase} from the model timeline.
  function automatic logic [4:0] exp_vec();
    logic [4:0] v;
    if (!m_busy) begin
      v = 5'b11001;
    end else begin
      v[4] = !((m_t >= m_E) && (m_t <= m_E + 2));
      v[3] = !((m_t >= m_E + 4) && (m_t <= m_E + 6));
      v[2] = (m_t == m_E + 1) || (m_t == m_E + 5);
      v[1] = (m_t < m_E);
      v[0] = 1'b0;
    end
    return v;
  endfunction

  // Advance one clock and compare every output with the model.
  task automatic tick();
    logic [4:0] got;
    logic [4:0] want;
    @(posedge clk);
    #1;
    got  = {NRE_1, NRE_2, ADC, expose, erase};
    want = exp_vec();
    checks++;
    if (got !== want) begin
      $display("FAIL model_cycle t=%0t got=%b want=%b", $time, got, want);
    end else begin
      passed++;
    end
`ifdef RE_BUSY_OUT_EN
    checks++;
    if (busy !== m_busy) begin
      $display("FAIL busy got=%b want=%b", busy, m_busy);
    end else begin
      passed++;
    end
`endif
  endtask

  // Run one capture from IDLE; returns expose-high cycles and non-IDLE cycles.
  task automatic capture(input int hold, input int pulse_k, input bit jiggle,
                         output int n_exp, output int n_len);
    bit done_f;
    done_f = 1'b0;
    n_exp  = 0;
    n_len  = 0;
    for (int k = 0; k < 200 && !done_f; k++) begin
      init = (k < hold) || (k == pulse_k);
      if (jiggle) begin
        increase = 1'($urandom & 1);
        decrease = 1'($urandom & 1);
      end
      tick();
      if (expose) n_exp++;
      if (!erase) n_len++;
      if (k > 0 && erase) done_f = 1'b1;
    end
    init = 1'b0;
    increase = 1'b0;
    decrease = 1'b0;
    checks++;
    if (!done_f) begin
      $display("FAIL capture_timeout got=running want=idle");
    end else begin
      passed++;
    end
  endtask

  task automatic idle_hold(input int n, input logic inc, input logic dec);
    increase = inc;
    decrease = dec;
    for (int k = 0; k < n; k++) tick();
    increase = 1'b0;
    decrease = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({NRE_1, NRE_2, ADC, expose, erase} !== 5'b11001) begin
      $display("FAIL reset_outputs got=%b want=11001", {NRE_1, NRE_2, ADC, expose, erase});
    end else begin
      passed++;
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_default();
    int ne, nl;
    capture(2, -1, 1'b0, ne, nl);
    checks++;
    if (ne !== 5) $display("FAIL default_expose got=%0d want=5", ne); else passed++;
    checks++;
    if (nl !== 12) $display("FAIL default_length got=%0d want=12", nl); else passed++;
  endtask

  task automatic test_adjust();
    int ne, nl;
    idle_hold(1, 1'b1, 1'b0);
    idle_hold(3, 1'b0, 1'b0);
    idle_hold(1, 1'b1, 1'b0);
    idle_hold(2, 1'b0, 1'b0);
    capture(1, -1, 1'b0, ne, nl);
    checks++;
    if (ne !== 7) $display("FAIL adjust_expose got=%0d want=7", ne); else passed++;
    checks++;
    if (nl !== 14) $display("FAIL adjust_length got=%0d want=14", nl); else passed++;
  endtask

  task automatic test_saturation();
    int ne, nl;
    idle_hold(40, 1'b1, 1'b0);
    capture(1, -1, 1'b0, ne, nl);
    checks++;
    if (ne !== 30) $display("FAIL sat_max got=%0d want=30", ne); else passed++;
    idle_hold(40, 1'b0, 1'b1);
    capture(1, -1, 1'b0, ne, nl);
    checks++;
    if (ne !== 2) $display("FAIL sat_min got=%0d want=2", ne); else passed++;
    idle_hold(3, 1'b1, 1'b0);
    idle_hold(10, 1'b1, 1'b1);
    capture(1, -1, 1'b0, ne, nl);
    checks++;
    if (ne !== 5) $display("FAIL both_pressed got=%0d want=5", ne); else passed++;
  endtask

  task automatic test_ignore_busy();
    int ne, nl;
    capture(1, -1, 1'b1, ne, nl);
    capture(1, -1, 1'b0, ne, nl);
    checks++;
    if (ne !== 5) $display("FAIL adjust_during_capture got=%0d want=5", ne); else passed++;
    capture(1, 3, 1'b0, ne, nl);
    checks++;
    if (nl !== 12) $display("FAIL init_during_expose got=%0d want=12", nl); else passed++;
    tick();
    tick();
    checks++;
    if (erase !== 1'b1) $display("FAIL no_restart got=%b want=1", erase); else passed++;
  endtask

  task automatic test_reset_mid();
    int ne, nl;
    idle_hold(1, 1'b1, 1'b0);
    init = 1'b1;
    tick();
    init = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({NRE_1, NRE_2, ADC, expose, erase} !== 5'b11001) begin
      $display("FAIL reset_mid_outputs got=%b want=11001", {NRE_1, NRE_2, ADC, expose, erase});
    end else begin
      passed++;
    end
    reset = 1'b0;
    tick();
    capture(1, -1, 1'b0, ne, nl);
    checks++;
    if (ne !== 5) $display("FAIL reset_mid_expose got=%0d want=5", ne); else passed++;
  endtask

  task automatic test_back_to_back();
    int n_idle;
    bit prev;
    n_idle = 0;
    prev = 1'b0;
    init = 1'b1;
    for (int k = 0; k < 39; k++) begin
      tick();
      if (erase) begin
        n_idle++;
        checks++;
        if (prev) $display("FAIL b2b_idle_run k=%0d got=2+ want=1", k); else passed++;
      end
      prev = erase;
    end
    init = 1'b0;
    tick();
    checks++;
    if (n_idle !== 3) $display("FAIL b2b_idle_count got=%0d want=3", n_idle); else passed++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      init     = ($urandom_range(7, 0) == 0);
      increase = 1'($urandom & 1);
      decrease = 1'($urandom & 1);
      reset    = ($urandom_range(59, 0) == 0);
      tick();
      checks++;
      if (!NRE_1 && !NRE_2) $display("FAIL nre_exclusive got=00 want=not-both-low"); else passed++;
      checks++;
      if (ADC && (NRE_1 == NRE_2)) $display("FAIL adc_window got=%b%b want=one-low", NRE_1, NRE_2); else passed++;
    end
    init = 1'b0;
    increase = 1'b0;
    decrease = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default();
    test_adjust();
    test_reset();
    test_saturation();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_reset();
    test_default();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
